// File: rtl/fault_blink_code_gen.sv
// fault_blink_code_gen
//   Converts a latched power-fault code into a repeating amber-LED blink
//   pattern: N pulses (N = code), a long pause, repeat. Code 0 means a solid
//   LED. All timing is measured in counted ticks of the shared slow strobe.
//
// Ports
//   sys_clk          in   system clock
//   reset_n          in   synchronous active-low reset
//   tick             in   one-cycle timebase strobe
//   fault_valid      in   a power fault is active
//   fault_code       in   fault code, sampled only at sequence start
//   power_fault      out  registered, 1 whenever the FSM is not IDLE
//   fault_blink_code out  registered LED pattern, 1 = LED on
//   seq_done         out  one-cycle pulse when a PAUSE phase completes
module fault_blink_code_gen #(
    parameter int CODE_W      = 4,
    parameter int CNT_W       = 8,
    parameter int ON_TICKS    = 4,
    parameter int OFF_TICKS   = 4,
    parameter int PAUSE_TICKS = 16
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              fault_valid,
    input  logic [CODE_W-1:0] fault_code,
    output logic              power_fault,
    output logic              fault_blink_code,
    output logic              seq_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON,
        S_OFF,
        S_PAUSE,
        S_SOLID
    } state_t;

    // Last count value of each phase: the phase ends on the tick that
    // arrives while the counter already holds K-1.
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_TICKS - 1);
    localparam logic [CODE_W-1:0] ONE       = CODE_W'(1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  tick_cnt, tick_cnt_nxt;
    logic [CODE_W-1:0] blink_cnt, blink_cnt_nxt;
    logic [CODE_W-1:0] code_lat, code_lat_nxt;
    logic              done_nxt;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            tick_cnt         <= '0;
            blink_cnt        <= '0;
            code_lat         <= '0;
            power_fault      <= 1'b0;
            fault_blink_code <= 1'b0;
            seq_done         <= 1'b0;
        end else begin
            state            <= state_nxt;
            tick_cnt         <= tick_cnt_nxt;
            blink_cnt        <= blink_cnt_nxt;
            code_lat         <= code_lat_nxt;
            // Outputs are registered from the next state so they line up
            // with the state register itself.
            power_fault      <= (state_nxt != S_IDLE);
            fault_blink_code <= (state_nxt == S_ON) || (state_nxt == S_SOLID);
            seq_done         <= done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        tick_cnt_nxt  = tick_cnt;
        blink_cnt_nxt = blink_cnt;
        code_lat_nxt  = code_lat;
        done_nxt      = 1'b0;

        // Fault drop wins over any phase end, including the final PAUSE tick.
        if (!fault_valid) begin
            state_nxt    = S_IDLE;
            tick_cnt_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    code_lat_nxt  = fault_code;
                    tick_cnt_nxt  = '0;
                    blink_cnt_nxt = ONE;
                    state_nxt     = (fault_code == '0) ? S_SOLID : S_ON;
                end
                S_ON: begin
                    if (tick) begin
                        if (tick_cnt == ON_LAST) begin
                            tick_cnt_nxt = '0;
                            state_nxt    = S_OFF;
                        end else begin
                            tick_cnt_nxt = tick_cnt + 1'b1;
                        end
                    end
                end
                S_OFF: begin
                    if (tick) begin
                        if (tick_cnt == OFF_LAST) begin
                            tick_cnt_nxt = '0;
                            if (blink_cnt == code_lat) begin
                                state_nxt = S_PAUSE;
                            end else begin
                                blink_cnt_nxt = blink_cnt + 1'b1;
                                state_nxt     = S_ON;
                            end
                        end else begin
                            tick_cnt_nxt = tick_cnt + 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (tick) begin
                        if (tick_cnt == PAUSE_LAST) begin
                            // Sequence boundary: the only place a new
                            // non-zero code is picked up while blinking.
                            done_nxt      = 1'b1;
                            tick_cnt_nxt  = '0;
                            code_lat_nxt  = fault_code;
                            blink_cnt_nxt = ONE;
                            state_nxt     = (fault_code == '0) ? S_SOLID : S_ON;
                        end else begin
                            tick_cnt_nxt = tick_cnt + 1'b1;
                        end
                    end
                end
                S_SOLID: begin
                    // A solid LED carries no sequence, so a new code starts
                    // blinking right away.
                    if (fault_code != '0) begin
                        code_lat_nxt  = fault_code;
                        blink_cnt_nxt = ONE;
                        tick_cnt_nxt  = '0;
                        state_nxt     = S_ON;
                    end
                end
                default: begin
                    state_nxt    = S_IDLE;
                    tick_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fault_blink_code_gen.sv
// tb_fault_blink_code_gen
//   Two instances share the same stimulus: u_dut with default timing and
//   u_dut2 with ON_TICKS=2. A tick-position model predicts outputs every cycle.
module tb_fault_blink_code_gen;

    localparam int OFF_T   = 4;
    localparam int PAUSE_T = 16;

    logic       sys_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       fault_valid = 1'b0;
    logic [3:0] fault_code = 4'd0;
    logic       pf1, led1, done1, pf2, led2, done2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    fault_blink_code_gen u_dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .tick(tick),
        .fault_valid(fault_valid), .fault_code(fault_code),
        .power_fault(pf1), .fault_blink_code(led1), .seq_done(done1)
    );

    fault_blink_code_gen #(.ON_TICKS(2)) u_dut2 (
        .sys_clk(sys_clk), .reset_n(reset_n), .tick(tick),
        .fault_valid(fault_valid), .fault_code(fault_code),
        .power_fault(pf2), .fault_blink_code(led2), .seq_done(done2)
    );

    // mode: 0 idle, 1 blinking, 2 solid. pos = ticks counted since the
    // current sequence started; the LED pattern is derived arithmetically.
    typedef struct {
        int mode;
        int pos;
        int code;
        bit pf;
        bit led;
        bit done;
    } mdl_t;

    mdl_t m1, m2;

    function automatic mdl_t mdl_next(mdl_t m, int on_t, bit r, bit f, bit t, int fc);
        mdl_t x;
        int   per;
        x      = m;
        x.done = 1'b0;
        per    = on_t + OFF_T;
        if (!r) begin
            x.mode = 0; x.pos = 0; x.code = 0;
        end else if (!f) begin
            x.mode = 0;
        end else if (m.mode == 0 || (m.mode == 2 && fc != 0)) begin
            x.code = fc; x.pos = 0; x.mode = (fc == 0) ? 2 : 1;
        end else if (m.mode == 1 && t) begin
            x.pos = m.pos + 1;
            if (x.pos == m.code * per + PAUSE_T) begin
                x.done = 1'b1; x.code = fc; x.pos = 0; x.mode = (fc == 0) ? 2 : 1;
            end
        end
        x.pf  = (x.mode != 0);
        x.led = (x.mode == 2) ||
                (x.mode == 1 && x.pos < x.code * per && (x.pos % per) < on_t);
        return x;
    endfunction

    task automatic chk(input string name, input logic act, input bit exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, advance model on the same sampled inputs, compare.
    task automatic step(input bit r, input bit f, input int c, input bit t);
        reset_n     = r;
        fault_valid = f;
        fault_code  = 4'(c);
        tick        = t;
        @(posedge sys_clk);
        m1 = mdl_next(m1, 4, r, f, t, c);
        m2 = mdl_next(m2, 2, r, f, t, c);
        #1;
        chk("pf1", pf1, m1.pf);   chk("led1", led1, m1.led); chk("done1", done1, m1.done);
        chk("pf2", pf2, m2.pf);   chk("led2", led2, m2.led); chk("done2", done2, m2.done);
    endtask

    // Steps with tick=1 until u_dut pulses seq_done; counts LED falling edges.
    task automatic run_seq(input int c, input int maxc, output int falls, output int len);
        logic prev;
        falls = 0;
        len   = 0;
        prev  = led1;
        for (int i = 0; i < maxc; i++) begin
            step(1, 1, c, 1);
            len++;
            if (prev && !led1) falls++;
            prev = led1;
            if (done1) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL seq_timeout: no seq_done within %0d cycles (code %0d)", maxc, c);
        len = -1;
    endtask

    typedef struct {
        bit r, f;
        int c;
        bit t;
        bit pf, led, done;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int falls, len, ndone, run, exp_run;
        m1 = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
        m2 = m1;

        // Directed vectors with hand-derived expectations (default timing).
        tbl[0]  = '{0, 1, 3, 1, 0, 0, 0};  // reset wins
        tbl[1]  = '{1, 0, 3, 1, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 1, 1, 1, 0};  // code 0 -> solid
        tbl[3]  = '{1, 1, 0, 1, 1, 1, 0};
        tbl[4]  = '{1, 1, 5, 0, 1, 1, 0};  // leave solid -> ON
        tbl[5]  = '{1, 1, 5, 0, 1, 1, 0};  // no tick, no progress
        tbl[6]  = '{1, 1, 5, 1, 1, 1, 0};
        tbl[7]  = '{1, 1, 5, 1, 1, 1, 0};
        tbl[8]  = '{1, 1, 5, 1, 1, 1, 0};
        tbl[9]  = '{1, 1, 5, 1, 1, 0, 0};  // 4th tick -> OFF
        tbl[10] = '{1, 0, 5, 1, 0, 0, 0};  // fault drop
        tbl[11] = '{1, 0, 5, 1, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].f, tbl[i].c, tbl[i].t);
            chk("tbl_pf", pf1, tbl[i].pf);
            chk("tbl_led", led1, tbl[i].led);
            chk("tbl_done", done1, tbl[i].done);
        end

        // Code 3, tick every cycle: 40-cycle period, three pulses.
        step(1, 1, 3, 1);
        chk("t1_latency_pf", pf1, 1'b1);
        run_seq(3, 60, falls, len);
        chk_int("t1_len", len, 40);   chk_int("t1_pulses", falls, 3);
        run_seq(3, 60, falls, len);
        chk_int("t1_period", len, 40); chk_int("t1_pulses2", falls, 3);

        // Solid, then code 2.
        step(1, 0, 0, 1);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, 1);
            if (done1) ndone++;
            chk("t2_solid", led1, 1'b1);
        end
        chk_int("t2_no_done", ndone, 0);
        run_seq(2, 60, falls, len);
        chk_int("t2_len", len, 33);   chk_int("t2_pulses", falls, 2);

        // Code change mid-ON takes effect at the sequence boundary.
        step(1, 0, 3, 1);
        step(1, 1, 3, 1);
        step(1, 1, 3, 1);
        step(1, 1, 1, 1);
        run_seq(1, 60, falls, len);
        chk_int("t3_len", len, 38);   chk_int("t3_pulses", falls, 3);
        run_seq(1, 60, falls, len);
        chk_int("t3_period", len, 24); chk_int("t3_pulses2", falls, 1);

        // Drop in OFF after pulse 2, then restart from pulse 1.
        step(1, 0, 3, 1);
        step(1, 1, 3, 1);
        for (int i = 0; i < 13; i++) step(1, 1, 3, 1);
        chk("t4_in_off", led1, 1'b0);
        step(1, 0, 3, 1);
        chk("t4_drop_pf", pf1, 1'b0); chk("t4_drop_led", led1, 1'b0);
        step(1, 1, 3, 1);
        chk("t4_restart_led", led1, 1'b1);
        run_seq(3, 60, falls, len);
        chk_int("t4_len", len, 40);   chk_int("t4_pulses", falls, 3);

        // Sparse tick, ON_TICKS=2 instance: ON length depends on tick phase.
        for (int ph = 0; ph < 4; ph++) begin
            step(1, 0, 1, 0);
            run = 0;
            for (int j = 0; j < 20; j++) begin
                step(1, 1, 1, (j % 4) == ph);
                if (!led2) break;
                run++;
            end
            exp_run = (ph == 0) ? 8 : 4 + ph;
            chk_int("t5_on_len", run, exp_run);
        end

        // Reset mid-PAUSE, then fresh latch.
        step(1, 0, 3, 1);
        step(1, 1, 3, 1);
        for (int i = 0; i < 30; i++) step(1, 1, 3, 1);
        step(0, 1, 3, 1);
        chk("t6_pf", pf1, 1'b0); chk("t6_led", led1, 1'b0); chk("t6_done", done1, 1'b0);
        step(1, 1, 2, 1);
        chk("t6_restart", led1, 1'b1);
        run_seq(2, 60, falls, len);
        chk_int("t6_len", len, 32);   chk_int("t6_pulses", falls, 2);

        // Random traffic against the model.
        begin
            int c;
            c = 3;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(29) == 0) c = $urandom_range(15);
                step($urandom_range(199) != 0, $urandom_range(49) != 0, c,
                     $urandom_range(1) == 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
